uart_rx: RTL and testbench

8N1 UART receiver for the Omdazz board's RS-232 input `UART_RXD`. It is the receive end of the serial link whose transmit pin is currently tied low at the top level. It recovers bytes from the asynchronous line at a fixed baud rate and presents each byte on a one-entry holding register with a valid/ready handshake. Downstream consumers (calculator value load, seven-segment display) read bytes from that register.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_if.sv | 19 +
 rtl/uart_sync2.sv | 25 ++
 rtl/uart_rx.sv | 147 ++++++++++++++
 tb/tb_uart_rx.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default clocking, bit-period derivation and the
// receiver state encoding. The transmitter reuses these constants.
package uart_pkg;

    localparam int unsigned DEF_CLK_FREQ = 50_000_000;
    localparam int unsigned DEF_BAUD     = 115_200;

    localparam logic [2:0] ENC_IDLE      = 3'd0;
    localparam logic [2:0] ENC_START     = 3'd1;
    localparam logic [2:0] ENC_DATA      = 3'd2;
    localparam logic [2:0] ENC_STOP      = 3'd3;
    localparam logic [2:0] ENC_WAIT_IDLE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = ENC_IDLE,
        ST_START     = ENC_START,
        ST_DATA      = ENC_DATA,
        ST_STOP      = ENC_STOP,
        ST_WAIT_IDLE = ENC_WAIT_IDLE
    } rx_state_t;

    // Integer division on purpose: the residual error is absorbed by mid-bit sampling.
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side byte handshake plus status flags between uart_rx and its consumer.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport master (
        output rx_data, rx_valid, frame_err, overrun, busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, overrun, busy,
        output rx_ready
    );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous inputs, with a configurable reset value
// so idle-high lines do not glitch low out of reset.
module uart_sync2 #(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry holding register and valid/ready handshake.
//
// state        | meaning
// ST_IDLE      | line idle, waiting for a falling edge
// ST_START     | timing to mid start bit to reject glitches
// ST_DATA      | sampling eight data bits, LSB first
// ST_STOP      | sampling the stop bit, deciding load / overrun / framing error
// ST_WAIT_IDLE | break or post-reset: wait for the line to be seen high
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = DEF_CLK_FREQ,
    parameter int unsigned BAUD         = DEF_BAUD,
    parameter int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD)
) (
    input  logic      FPGA_CLK,
    input  logic      RESET,
    input  logic      UART_RXD,
    uart_rx_if.master rx
);

    localparam int unsigned HALF = CLKS_PER_BIT / 2;
    localparam int          TW   = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_HALF = TW'(HALF - 1);
    localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);

    logic          rxd_s;
    rx_state_t     state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [2:0]    bit_idx, idx_nxt;
    logic [7:0]    shift_q, shift_nxt;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          ferr_q, ferr_nxt;
    logic          ovr_q, ovr_nxt;
    logic          load;
    logic [1:0]    settle;
    logic          armed;

    uart_sync2 #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
        .clk (FPGA_CLK),
        .rst (RESET),
        .d   (UART_RXD),
        .q   (rxd_s)
    );

    // The synchronizer's reset value is not a real observation of the line, so
    // a start is only trusted once rxd_s has been high after the flops refilled.
    always_ff @(posedge FPGA_CLK) begin
        if (RESET) begin
            settle <= '0;
            armed  <= 1'b0;
        end else begin
            settle <= {settle[0], 1'b1};
            if (settle[1] && rxd_s) armed <= 1'b1;
        end
    end

    always_ff @(posedge FPGA_CLK) begin
        if (RESET) begin
            state   <= ST_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift_q <= '0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            bit_idx <= idx_nxt;
            shift_q <= shift_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer + 1'b1;
        idx_nxt   = bit_idx;
        shift_nxt = shift_q;
        load      = 1'b0;
        ferr_nxt  = 1'b0;
        ovr_nxt   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                timer_nxt = '0;
                if (!rxd_s) state_nxt = armed ? ST_START : ST_WAIT_IDLE;
            end
            ST_START: begin
                if (timer == T_HALF) begin
                    timer_nxt = '0;
                    idx_nxt   = '0;
                    state_nxt = rxd_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (timer == T_FULL) begin
                    timer_nxt          = '0;
                    shift_nxt[bit_idx] = rxd_s;
                    idx_nxt            = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (timer == T_FULL) begin
                    timer_nxt = '0;
                    if (rxd_s) begin
                        state_nxt = ST_IDLE;
                        if (valid_q) ovr_nxt = 1'b1;
                        else         load    = 1'b1;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                timer_nxt = '0;
                if (rxd_s && settle[1]) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A load beats a same-cycle transfer so a fresh byte is never lost.
    always_ff @(posedge FPGA_CLK) begin
        if (RESET) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ferr_q <= ferr_nxt;
            ovr_q  <= ovr_nxt;
            if (load) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
            end else if (valid_q && rx.rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx.rx_data   = data_q;
    assign rx.rx_valid  = valid_q;
    assign rx.frame_err = ferr_q;
    assign rx.overrun   = ovr_q;
    assign rx.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit: frame-level reference model with
// event timing from the bit-period arithmetic, directed corners and random traffic.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 2 + HALF + 9 * CPB + 1;   // line fall to flag/valid update

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;

    uart_rx_if rxi ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .FPGA_CLK (clk),
        .RESET    (rst),
        .UART_RXD (rxd),
        .rx       (rxi.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       good;
    } evt_t;

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    evt_t       evq[$];
    logic [7:0] seen[$];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    int         ferr_cnt = 0;
    int         ovr_cnt = 0;
    int         vhigh = 0;
    int         valid_rise = -1;
    int         last_fall = 0;
    logic       last_valid = 1'b0;
    logic       rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Advance one clock; model the holding register from frame completion events.
    task automatic step();
        logic p_ready, p_valid, p_rst;
        logic exp_ferr, exp_ovr;
        evt_t e;
        p_ready = rxi.rx_ready;
        p_valid = m_valid;
        p_rst   = rst;
        @(posedge clk);
        #1;
        cyc++;
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        if (p_rst) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            evq.delete();
        end else begin
            if (p_valid && p_ready) m_valid = 1'b0;
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                e = evq.pop_front();
                if (!e.good)     exp_ferr = 1'b1;
                else if (p_valid) exp_ovr = 1'b1;
                else begin
                    m_valid = 1'b1;
                    m_data  = e.data;
                end
            end
        end
        check("valid", rxi.rx_valid, m_valid);
        if (m_valid) check("data", rxi.rx_data, m_data);
        check("frame_err", rxi.frame_err, exp_ferr);
        check("overrun", rxi.overrun, exp_ovr);
        if (rxi.frame_err === 1'b1) ferr_cnt++;
        if (rxi.overrun === 1'b1) ovr_cnt++;
        if (rxi.rx_valid === 1'b1) vhigh++;
        if (rxi.rx_valid === 1'b1 && last_valid !== 1'b1) begin
            valid_rise = cyc;
            seen.push_back(rxi.rx_data);
        end
        last_valid = rxi.rx_valid;
        if (rand_ready) rxi.rx_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) step();
    endtask

    // Leaves the line at the stop value; a bad stop keeps it low.
    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        evt_t e;
        e.cyc  = cyc + LAT;
        e.data = b;
        e.good = stop_ok;
        evq.push_back(e);
        last_fall = cyc;
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      rxd = 1'b0;
            else if (i == 9) rxd = stop_ok;
            else             rxd = b[i-1];
            repeat (CPB) step();
        end
    endtask

    initial begin
        vec_t       tbl[6];
        logic [7:0] b55;
        logic [7:0] rb;
        logic       rok;
        int f0, o0, vh0, bad, busy_hi, bl;

        tbl[0] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 0};
        tbl[1] = '{8'h01, 1'b1, 1'b1, 8'h01, 0};
        tbl[2] = '{8'h80, 1'b1, 1'b1, 8'h80, 0};
        tbl[3] = '{8'hC3, 1'b0, 1'b0, 8'h00, 1};
        tbl[4] = '{8'h7E, 1'b1, 1'b1, 8'h7E, 0};
        tbl[5] = '{8'hF0, 1'b1, 1'b1, 8'hF0, 0};
        b55 = 8'h55;

        rxi.rx_ready = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        check("rst_data", rxi.rx_data, 8'h00);
        check("rst_valid", rxi.rx_valid, 1'b0);
        check("rst_busy", rxi.busy, 1'b0);
        check("rst_frame_err", rxi.frame_err, 1'b0);
        check("rst_overrun", rxi.overrun, 1'b0);
        rst = 1'b0;
        idle(2 * CPB);

        // 0xA5, consumer stalled
        send_byte(8'hA5, 1'b1);
        idle(4);
        check("a5_latency", valid_rise - last_fall, 155);
        check("a5_data", rxi.rx_data, 8'hA5);
        check("a5_valid", rxi.rx_valid, 1'b1);
        check("a5_flags", ferr_cnt + ovr_cnt, 0);
        rxi.rx_ready = 1'b1;
        step();
        rxi.rx_ready = 1'b0;
        check("a5_consumed", rxi.rx_valid, 1'b0);
        idle(CPB);

        // 5-cycle glitch: start rejected at mid start bit
        f0 = ferr_cnt;
        bad = 0;
        busy_hi = 0;
        rxd = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            step();
            if (k == 5) rxd = 1'b1;
            if (rxi.busy === 1'b1) busy_hi++;
            if (rxi.busy !== ((k >= 3) && (k <= 2 + HALF))) bad++;
        end
        check("glitch_busy_shape", bad, 0);
        check("glitch_busy_len", busy_hi, HALF);
        check("glitch_no_valid", rxi.rx_valid, 1'b0);
        check("glitch_no_ferr", ferr_cnt - f0, 0);

        // bad stop, then the line held low as a break
        f0 = ferr_cnt;
        send_byte(8'h3C, 1'b0);
        bl = 0;
        repeat (40) begin
            step();
            if (rxi.busy !== 1'b1) bl++;
        end
        check("break_ferr_once", ferr_cnt - f0, 1);
        check("break_no_valid", rxi.rx_valid, 1'b0);
        check("break_busy_held", bl, 0);
        rxd = 1'b1;
        repeat (4) step();
        check("break_release", rxi.busy, 1'b0);
        idle(CPB);

        // back-to-back with consumer stalled
        o0 = ovr_cnt;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        idle(4);
        check("ovr_once", ovr_cnt - o0, 1);
        check("ovr_keep_old", rxi.rx_data, 8'h11);
        check("ovr_valid", rxi.rx_valid, 1'b1);
        rxi.rx_ready = 1'b1;
        step();
        rxi.rx_ready = 1'b0;
        check("ovr_consumed", rxi.rx_valid, 1'b0);
        idle(CPB);

        // consumer always ready
        seen.delete();
        vh0 = vhigh;
        rxi.rx_ready = 1'b1;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        idle(4);
        rxi.rx_ready = 1'b0;
        check("rdy_pulses", seen.size(), 2);
        check("rdy_high_cycles", vhigh - vh0, 2);
        if (seen.size() == 2) begin
            check("rdy_byte0", seen[0], 8'h00);
            check("rdy_byte1", seen[1], 8'hFF);
        end
        idle(CPB);

        // reset during data bit 3 of 0x55, then 0x99
        seen.delete();
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        rxd = 1'b0;
        repeat (CPB) step();
        for (int i = 0; i < 3; i++) begin
            rxd = b55[i];
            repeat (CPB) step();
        end
        rxd = b55[3];
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (CPB - 5) step();
        idle(CPB);
        send_byte(8'h99, 1'b1);
        idle(4);
        check("rstmid_count", seen.size(), 1);
        if (seen.size() == 1) check("rstmid_byte", seen[0], 8'h99);
        check("rstmid_data", rxi.rx_data, 8'h99);
        check("rstmid_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
        rxi.rx_ready = 1'b1;
        step();
        rxi.rx_ready = 1'b0;
        idle(CPB);

        for (int i = 0; i < 6; i++) begin
            f0 = ferr_cnt;
            send_byte(tbl[i].data, tbl[i].stop_ok);
            idle(CPB);
            check("tbl_valid", rxi.rx_valid, tbl[i].exp_valid);
            if (tbl[i].exp_valid) check("tbl_data", rxi.rx_data, tbl[i].exp_data);
            check("tbl_ferr", ferr_cnt - f0, tbl[i].exp_ferr);
            rxi.rx_ready = 1'b1;
            step();
            rxi.rx_ready = 1'b0;
        end

        // random bytes, random stop faults, random gaps and random consumer
        rand_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            rb  = 8'($urandom_range(0, 255));
            rok = ($urandom_range(0, 5) != 0);
            send_byte(rb, rok);
            idle(rok ? int'($urandom_range(0, 20)) : int'($urandom_range(4, 20)));
        end
        idle(LAT);
        rand_ready = 1'b0;
        rxi.rx_ready = 1'b0;
        idle(4);
        check("events_drained", evq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
